data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the block-wide data memory. The CPU presents an 8-bit byte address (ALURESULT) with READ/WRITE strobes. The cache answers hits with zero wait states and stalls the CPU through BUSYWAIT on misses while it writes back or refills a 4-byte block. The cache is the sole master of the data memory port.

---
 rtl/data_cache_pkg.sv | 17 +
 rtl/dcache_fsm.sv | 97 +++++++++
 rtl/data_cache.sv | 139 +++++++++++++
 tb/tb_data_cache.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data_cache slice.
//   - Field widths of the 8-bit CPU byte address: tag | index | offset.
//   - Miss-handling FSM state encoding used by data_cache and dcache_fsm.
package data_cache_pkg;

  localparam int unsigned INDEX_BITS  = 3;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned TAG_BITS    = 6 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BACK,
    ST_FETCH,
    ST_UPDATE
  } state_e;

endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling sequencer for data_cache.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_i           - CPU READ or WRITE is asserted
//   hit_i           - addressed line is valid with a matching tag
//   line_dirty_i    - addressed line is valid and dirty (needs write-back)
//   req_tag_i       - tag field of the CPU address
//   stored_tag_i    - tag currently held by the addressed line
//   index_i         - index field of the CPU address
//   mem_busywait_i  - memory busy; low while a request is held = completion
//   state_o         - current FSM state
//   mem_read_o      - block fetch request (registered)
//   mem_write_o     - block write-back request (registered)
//   mem_address_o   - block address {tag, index} (registered)
module dcache_fsm
  import data_cache_pkg::*;
#(
  parameter int unsigned IDX_W = INDEX_BITS,
  parameter int unsigned TAG_W = TAG_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   hit_i,
  input  logic                   line_dirty_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  input  logic [TAG_W-1:0]       stored_tag_i,
  input  logic [IDX_W-1:0]       index_i,
  input  logic                   mem_busywait_i,
  output state_e                 state_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [TAG_W+IDX_W-1:0] mem_address_o
);

  state_e                 state_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [TAG_W+IDX_W-1:0] mem_address_q;

  // Memory strobes are loaded together with the state they belong to, so
  // they are high exactly while the FSM sits in WRITE_BACK / FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i && !hit_i) begin
            if (line_dirty_i) begin
              state_q       <= ST_WRITE_BACK;
              mem_write_q   <= 1'b1;
              mem_address_q <= {stored_tag_i, index_i};
            end else begin
              state_q       <= ST_FETCH;
              mem_read_q    <= 1'b1;
              mem_address_q <= {req_tag_i, index_i};
            end
          end
        end
        ST_WRITE_BACK: begin
          if (!mem_busywait_i) begin
            state_q       <= ST_FETCH;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= {req_tag_i, index_i};
          end
        end
        ST_FETCH: begin
          if (!mem_busywait_i) begin
            state_q       <= ST_UPDATE;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
          end
        end
        ST_UPDATE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q       <= ST_IDLE;
          mem_read_q    <= 1'b0;
          mem_write_q   <= 1'b0;
          mem_address_q <= '0;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache (4-byte blocks).
// Ports:
//   CLK, RESET      - clock, asynchronous active-high reset
//   READ, WRITE     - CPU load / store strobes, held until BUSYWAIT is low
//   ADDRESS         - CPU byte address {tag, index, offset}
//   WRITEDATA       - store byte
//   READDATA        - load byte (valid while READ hits in IDLE)
//   BUSYWAIT        - CPU stall
//   MEM_READ        - block fetch request
//   MEM_WRITE       - block write-back request
//   MEM_ADDRESS     - block address {tag, index}
//   MEM_WRITEDATA   - write-back block, byte0 in [7:0]
//   MEM_READDATA    - fetched block, byte0 in [7:0]
//   MEM_BUSYWAIT    - memory busy; completion when low while request held
module data_cache #(
  parameter int unsigned INDEX_BITS  = data_cache_pkg::INDEX_BITS,
  parameter int unsigned BLOCK_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);
  import data_cache_pkg::*;

  localparam int unsigned OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W    = 6 - INDEX_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;

  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [OFFSET_W-1:0]   addr_offset;

  assign addr_tag    = ADDRESS[7 -: TAG_W];
  assign addr_index  = ADDRESS[OFFSET_W +: INDEX_BITS];
  assign addr_offset = ADDRESS[OFFSET_W-1:0];

  logic             valid_q [LINES];
  logic             valid_d [LINES];
  logic             dirty_q [LINES];
  logic             dirty_d [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [TAG_W-1:0] tag_d   [LINES];
  logic [31:0]      data_q  [LINES];
  logic [31:0]      data_d  [LINES];
  logic [31:0]      fetch_q;
  logic [31:0]      fetch_d;

  state_e      state;
  logic        req;
  logic        hit;
  logic        idle;
  logic        line_dirty;
  logic [31:0] cur_block;
  logic [7:0]  cur_byte;

  assign req        = READ | WRITE;
  assign idle       = (state == ST_IDLE);
  assign hit        = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign line_dirty = valid_q[addr_index] && dirty_q[addr_index];
  assign cur_block  = data_q[addr_index];
  assign cur_byte   = cur_block[{addr_offset, 3'b000} +: 8];

  // A store that missed completes as an ordinary write hit in the IDLE
  // cycle after UPDATE, so the byte merge only ever happens here.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    fetch_d = fetch_q;
    if (state == ST_FETCH && !MEM_BUSYWAIT) begin
      fetch_d = MEM_READDATA;
    end
    if (state == ST_UPDATE) begin
      data_d[addr_index]  = fetch_q;
      tag_d[addr_index]   = addr_tag;
      valid_d[addr_index] = 1'b1;
      dirty_d[addr_index] = 1'b0;
    end
    if (WRITE && idle && hit) begin
      data_d[addr_index][{addr_offset, 3'b000} +: 8] = WRITEDATA;
      dirty_d[addr_index] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '{default: 1'b0};
      dirty_q <= '{default: 1'b0};
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    tag_q   <= tag_d;
    data_q  <= data_d;
    fetch_q <= fetch_d;
  end

  dcache_fsm #(
    .IDX_W (INDEX_BITS),
    .TAG_W (TAG_W)
  ) u_fsm (
    .clk            (CLK),
    .rst            (RESET),
    .req_i          (req),
    .hit_i          (hit),
    .line_dirty_i   (line_dirty),
    .req_tag_i      (addr_tag),
    .stored_tag_i   (tag_q[addr_index]),
    .index_i        (addr_index),
    .mem_busywait_i (MEM_BUSYWAIT),
    .state_o        (state),
    .mem_read_o     (MEM_READ),
    .mem_write_o    (MEM_WRITE),
    .mem_address_o  (MEM_ADDRESS)
  );

  // The index is held stable for the whole miss, so the victim block can be
  // presented straight from the array while in WRITE_BACK.
  assign MEM_WRITEDATA = (state == ST_WRITE_BACK) ? data_q[addr_index] : '0;
  assign READDATA      = (READ && idle && hit) ? cur_byte : '0;
  assign BUSYWAIT      = req && !(idle && hit) && !RESET;

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  data_cache #(
    .INDEX_BITS  (3),
    .BLOCK_BYTES (4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned vectors;
  int unsigned miscompares;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endfunction

  // ---------------- backing memory (random latency) ----------------
  logic [31:0] bmem [64];
  int unsigned mem_cnt;
  int unsigned mem_lat;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);
  assign MEM_READDATA = bmem[MEM_ADDRESS];

  initial begin
    for (int i = 0; i < 64; i++) bmem[i] = $urandom;
    mem_cnt = 0;
    mem_lat = 1;
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        mem_cnt <= 0;
      end else if (MEM_READ || MEM_WRITE) begin
        if (!MEM_BUSYWAIT) begin
          if (MEM_WRITE) bmem[MEM_ADDRESS] <= MEM_WRITEDATA;
          mem_cnt <= 0;
          mem_lat <= $urandom_range(0, 3);
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // CPU-visible byte memory plus which block each line holds and whether
  // that line holds stores the backing memory has not seen yet.
  logic [7:0] ref_mem [256];
  bit         m_valid [8];
  bit         m_dirty [8];
  int unsigned m_blk  [8];

  typedef struct {
    bit          is_read;
    logic [7:0]  addr;
    logic [7:0]  rdata;
    bit          miss;
    bit          exp_wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_block;
    logic [5:0]  fetch_addr;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [31:0] ref_block(input int unsigned blk);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[k*8 +: 8] = ref_mem[blk*4 + k];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_blk[i]   = 0;
    end
    // Unwritten-back stores are lost: the visible memory is what memory holds.
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) ref_mem[b*4 + k] = bmem[b][k*8 +: 8];
  endtask

  task automatic predict(input bit rd, input logic [7:0] a, input logic [7:0] d, output exp_t e);
    int unsigned blk;
    int unsigned line;
    blk  = a / 4;
    line = blk % 8;
    e.is_read    = rd;
    e.addr       = a;
    e.miss       = !(m_valid[line] && m_blk[line] == blk);
    e.exp_wb     = e.miss && m_valid[line] && m_dirty[line];
    e.wb_addr    = 6'(m_blk[line]);
    e.wb_block   = ref_block(m_blk[line]);
    e.fetch_addr = 6'(blk);
    if (e.miss) begin
      m_valid[line] = 1;
      m_blk[line]   = blk;
      m_dirty[line] = 0;
    end
    if (!rd) begin
      ref_mem[a]    = d;
      m_dirty[line] = 1;
    end
    e.rdata = ref_mem[a];
  endtask

  // ---------------- monitor ----------------
  int unsigned mem_cycles;
  int unsigned stall_cycles;
  int unsigned seen_wb;
  int unsigned seen_fetch;
  exp_t        mon_e;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (MEM_READ || MEM_WRITE) begin
        mem_cycles++;
        check("mem_rw_exclusive", {31'b0, MEM_READ & MEM_WRITE}, 32'd0);
      end
      if ((READ || WRITE) && BUSYWAIT) stall_cycles++;
      if (!READ && !WRITE) begin
        check("idle_busywait", {31'b0, BUSYWAIT}, 32'd0);
        check("idle_mem_req", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
      end
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        seen_wb++;
        if (sb_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          check("wb_expected", 32'd1, {31'b0, sb_q[0].exp_wb});
          check("wb_addr", {26'b0, MEM_ADDRESS}, {26'b0, sb_q[0].wb_addr});
          check("wb_data", MEM_WRITEDATA, sb_q[0].wb_block);
        end
      end
      if (MEM_READ && !MEM_BUSYWAIT) begin
        seen_fetch++;
        if (sb_q.size() == 0) begin
          check("fetch_unexpected", 32'd1, 32'd0);
        end else begin
          check("fetch_addr", {26'b0, MEM_ADDRESS}, {26'b0, sb_q[0].fetch_addr});
        end
      end
      if ((READ || WRITE) && !BUSYWAIT) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_addr", {24'b0, ADDRESS}, {24'b0, mon_e.addr});
          if (mon_e.is_read) check("readdata", {24'b0, READDATA}, {24'b0, mon_e.rdata});
          check("wb_count", seen_wb, {31'b0, mon_e.exp_wb});
          check("fetch_count", seen_fetch, {31'b0, mon_e.miss});
          // Miss: IDLE decision cycle + memory cycles + UPDATE; hit: none.
          check("stall_cycles", stall_cycles, mon_e.miss ? mem_cycles + 2 : 0);
        end
        mem_cycles   = 0;
        stall_cycles = 0;
        seen_wb      = 0;
        seen_fetch   = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic timeout(input string nm);
    miscompares++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
    summary();
    $finish;
  endtask

  task automatic access(input bit rd, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int unsigned n;
    predict(rd, a, d, e);
    sb_q.push_back(e);
    READ      = rd;
    WRITE     = !rd;
    ADDRESS   = a;
    WRITEDATA = rd ? 8'($urandom) : d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSYWAIT && n < 200);
    if (BUSYWAIT) timeout("access_wait");
    @(posedge CLK);
    #1;
    READ  = 0;
    WRITE = 0;
  endtask

  task automatic idle_gap(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      ADDRESS   = 8'($urandom);
      WRITEDATA = 8'($urandom);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic reset_midfetch(input logic [7:0] a);
    exp_t e;
    int unsigned n;
    predict(1, a, 8'h00, e);
    sb_q.push_back(e);
    READ    = 1;
    WRITE   = 0;
    ADDRESS = a;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MEM_READ && n < 200);
    if (!MEM_READ) timeout("reset_wait_fetch");
    #1;
    RESET = 1;
    #1;
    check("rst_mem_read", {31'b0, MEM_READ}, 32'd0);
    check("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
    check("rst_mem_write", {31'b0, MEM_WRITE}, 32'd0);
    check("rst_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
    READ = 0;
    sb_q.delete();
    mem_cycles   = 0;
    stall_cycles = 0;
    seen_wb      = 0;
    seen_fetch   = 0;
    @(posedge CLK);
    #1;
    model_reset();
    RESET = 0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_cycles   = 0;
    stall_cycles = 0;
    seen_wb      = 0;
    seen_fetch   = 0;
    READ      = 0;
    WRITE     = 0;
    ADDRESS   = 8'h00;
    WRITEDATA = 8'h00;
    RESET     = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_busywait", {31'b0, BUSYWAIT}, 32'd0);
    check("reset_mem_read", {31'b0, MEM_READ}, 32'd0);
    check("reset_mem_write", {31'b0, MEM_WRITE}, 32'd0);
    check("reset_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
    check("reset_mem_writedata", MEM_WRITEDATA, 32'd0);
    check("reset_readdata", {24'b0, READDATA}, 32'd0);
    model_reset();
    RESET = 0;
    @(posedge CLK);
    #1;

    access(1, 8'h05, 8'h00);   // cold miss, fetch block 0x01
    access(1, 8'h05, 8'h00);   // hit, no stall
    access(0, 8'h06, 8'hAB);   // write hit, line 1 dirty
    access(1, 8'h06, 8'h00);   // reads back 0xAB
    access(1, 8'h25, 8'h00);   // conflict: write back 0x01, fetch 0x09
    access(0, 8'h40, 8'h5C);   // write-allocate into invalid line 0
    access(1, 8'h00, 8'h00);   // evicts the dirty 0x40 block
    idle_gap(3);
    reset_midfetch(8'h85);
    access(1, 8'h85, 8'h00);   // misses again after reset

    for (int i = 0; i < 250; i++) begin
      logic [7:0] a;
      a = {3'($urandom_range(0, 2)), 5'($urandom)};
      access(1'($urandom), a, 8'($urandom));
      idle_gap($urandom_range(0, 2));
    end

    idle_gap(4);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    summary();
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

endmodule
